// File: rtl/ad_pkg.sv
// ad_pkg: shared defaults, FSM state types and width helper for the AD ping-pong buffer
package ad_pkg;
    localparam int AD_WIDTH_DEF = 16;

    typedef enum logic {FILL, DROP} wr_state_t;
    typedef enum logic {IDLE, READ} rd_state_t;

    function automatic int clogw(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/pp_ram.sv
// pp_ram: simple dual-port RAM with one-cycle synchronous read, address MSB selects the bank
module pp_ram #(
    parameter int W  = 16,
    parameter int AW = 9
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);
    logic [W-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/ad_pingpong_buf.sv
// ad_pingpong_buf: two-bank frame buffer from AD samples to a valid/ready stream with whole-frame overflow drop
module ad_pingpong_buf
    import ad_pkg::*;
#(
    parameter int AD_WIDTH  = AD_WIDTH_DEF,
    parameter int CH_NUM    = 1,
    parameter int FRAME_LEN = 256,
    parameter int CNT_W     = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [AD_WIDTH-1:0]        ad_data,
    input  logic                       ad_vaild,
    output logic [AD_WIDTH-1:0]        out_data,
    output logic [clogw(CH_NUM)-1:0]   out_ch,
    output logic                       out_last,
    output logic                       out_vaild,
    input  logic                       out_ready,
    input  logic                       clr_ovf,
    output logic                       overflow,
    output logic [CNT_W-1:0]           drop_cnt
);
    localparam int D   = FRAME_LEN * CH_NUM;
    localparam int AW  = clogw(D);
    localparam int CHW = clogw(CH_NUM);
    localparam logic [AW-1:0]  LAST_IDX = AW'(D - 1);
    localparam logic [CHW-1:0] LAST_CH  = CHW'(CH_NUM - 1);
    localparam logic [AW:0]    D_CNT    = (AW + 1)'(D);

    wr_state_t ws, ws_n;
    rd_state_t rs, rs_n;
    logic wbank, wbank_n, rbank, cur;
    logic [1:0] full, full_n;
    logic [AW-1:0] widx, widx_n;
    logic [CHW-1:0] ph, rch, pend_ch;
    logic [AW:0] rcnt;
    logic leave, fill, wr_en, complete, other_free, cur_free, drop;
    logic pop, rd_done, start, issue, space, pend, pend_last, rp, wp;
    logic [1:0] cnt;
    logic [AD_WIDTH-1:0] rdata;
    logic [AD_WIDTH-1:0] sk_data [2];
    logic [CHW-1:0] sk_ch [2];
    logic [1:0] sk_last;

    assign pop     = out_vaild & out_ready;
    assign rd_done = pop & out_last;

    // a bank freed by the reader this cycle counts as empty for the writer
    assign other_free = ~full[~wbank] | (rd_done & (rbank != wbank));
    assign leave      = (ws == DROP) & other_free & (ph == '0);
    assign fill       = (ws == FILL) | leave;
    assign cur        = wbank ^ leave;
    assign cur_free   = ~full[~cur] | (rd_done & (rbank != cur));
    assign wr_en      = ad_vaild & fill;
    assign complete   = wr_en & (widx == LAST_IDX);
    assign drop       = ad_vaild & ~fill;
    assign widx_n     = complete ? '0 : widx + AW'(wr_en);
    assign wbank_n    = cur ^ (complete & cur_free);
    assign ws_n       = (fill & ~(complete & ~cur_free)) ? FILL : DROP;

    always_comb begin
        full_n = full;
        if (rd_done) full_n[rbank] = 1'b0;
        if (complete) full_n[cur] = 1'b1;
    end

    // in-flight read plus skid occupancy never exceeds the two skid slots
    assign start = (rs == IDLE) & full[rbank];
    assign space = ({1'b0, cnt} + {2'b0, pend}) < (3'd2 + {2'b0, pop});
    assign issue = (start | ((rs == READ) & (rcnt != D_CNT))) & space;
    assign rs_n  = rd_done ? IDLE : (start ? READ : rs);

    assign out_vaild = cnt != 2'd0;
    assign out_data  = sk_data[rp];
    assign out_ch    = sk_ch[rp];
    assign out_last  = sk_last[rp];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ws       <= FILL;
            wbank    <= 1'b0;
            widx     <= '0;
            ph       <= '0;
            full     <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else begin
            ws    <= ws_n;
            wbank <= wbank_n;
            widx  <= widx_n;
            full  <= full_n;
            if (ad_vaild) ph <= (ph == LAST_CH) ? '0 : ph + CHW'(1);
            if (clr_ovf) begin
                overflow <= 1'b0;
                drop_cnt <= '0;
            end else if (drop) begin
                overflow <= 1'b1;
                drop_cnt <= drop_cnt + CNT_W'(~&drop_cnt);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rs         <= IDLE;
            rbank      <= 1'b0;
            rcnt       <= '0;
            rch        <= '0;
            pend       <= 1'b0;
            pend_ch    <= '0;
            pend_last  <= 1'b0;
            cnt        <= 2'd0;
            rp         <= 1'b0;
            wp         <= 1'b0;
            sk_data[0] <= '0;
            sk_data[1] <= '0;
            sk_ch[0]   <= '0;
            sk_ch[1]   <= '0;
            sk_last    <= '0;
        end else begin
            rs   <= rs_n;
            pend <= issue;
            if (rd_done) begin
                rbank <= ~rbank;
                rcnt  <= '0;
                rch   <= '0;
            end else if (issue) begin
                rcnt      <= rcnt + (AW + 1)'(1);
                rch       <= (rch == LAST_CH) ? '0 : rch + CHW'(1);
                pend_ch   <= rch;
                pend_last <= rcnt[AW-1:0] == LAST_IDX;
            end
            if (pend) begin
                sk_data[wp] <= rdata;
                sk_ch[wp]   <= pend_ch;
                sk_last[wp] <= pend_last;
                wp          <= ~wp;
            end
            if (pop) rp <= ~rp;
            cnt <= cnt + {1'b0, pend} - {1'b0, pop};
        end
    end

    pp_ram #(.W(AD_WIDTH), .AW(AW + 1)) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr ({cur, widx}),
        .wdata (ad_data),
        .re    (issue),
        .raddr ({rbank, rcnt[AW-1:0]}),
        .rdata (rdata)
    );
endmodule

// File: tb/tb_ad_pingpong_buf.sv
// tb_ad_pingpong_buf: randomized scoreboard bench against a frame-level model of the ping-pong buffer
module tb_ad_pingpong_buf;
    localparam int W = 16, CH = 2, FL = 4, D = 8, CW = 16;

    logic clk = 1'b0, reset = 1'b1;
    logic [W-1:0] ad_data = '0;
    logic ad_vaild = 1'b0, out_ready = 1'b0, clr_ovf = 1'b0;
    logic [W-1:0] out_data;
    logic [0:0] out_ch;
    logic out_last, out_vaild, overflow;
    logic [CW-1:0] drop_cnt;

    ad_pingpong_buf #(.AD_WIDTH(W), .CH_NUM(CH), .FRAME_LEN(FL), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .ad_data(ad_data), .ad_vaild(ad_vaild),
        .out_data(out_data), .out_ch(out_ch), .out_last(out_last), .out_vaild(out_vaild),
        .out_ready(out_ready), .clr_ovf(clr_ovf), .overflow(overflow), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {logic [W-1:0] d; logic [0:0] c; logic l;} exp_t;
    exp_t exp_q[$];
    logic [W-1:0] part[$];
    int vec = 0, bad = 0, mode = 0;
    int held = 0, ph = 0, exp_drop = 0;
    bit dropping = 0, exp_ovf = 0, free_evt = 0, coincide = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        vec++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
        end
    endtask

    always begin
        @(posedge clk);
        #2;
        out_ready = (mode == 2) ? 1'($urandom_range(0, 1)) : (mode == 1);
    end

    // frame-level model: a frame is held from completion until its last sample is accepted
    exp_t me;
    bit fr;
    always begin
        @(negedge clk);
        #1;
        if (!reset) begin
            exp_q.delete();
            part.delete();
            held = 0; ph = 0; dropping = 0; exp_drop = 0; exp_ovf = 0; free_evt = 0;
        end else begin
            fr = free_evt;
            free_evt = 0;
            if (fr) held--;
            if (dropping && held < 2 && ph == 0) dropping = 0;
            if (ad_vaild) begin
                if (!dropping) begin
                    part.push_back(ad_data);
                    if (part.size() == D) begin
                        for (int i = 0; i < D; i++) begin
                            me.d = part[i];
                            me.c = 1'(i % CH);
                            me.l = (i == D - 1);
                            exp_q.push_back(me);
                        end
                        part.delete();
                        held++;
                        if (fr) coincide = 1;
                        if (held == 2) dropping = 1;
                    end
                end else begin
                    if (exp_drop < 65535) exp_drop++;
                    exp_ovf = 1;
                end
                ph = (ph + 1) % CH;
            end
            if (clr_ovf) begin
                exp_drop = 0;
                exp_ovf = 0;
            end
        end
    end

    exp_t ge;
    bit stall = 0;
    logic [W-1:0] pd;
    logic [0:0] pc;
    logic pl;
    always begin
        @(negedge clk);
        if (!reset) stall = 0;
        else begin
            if (stall) begin
                check("hold_vaild", out_vaild, 1);
                check("hold_data", out_data, pd);
                check("hold_ch", out_ch, pc);
                check("hold_last", out_last, pl);
            end
            if (out_vaild && out_ready) begin
                if (exp_q.size() == 0) begin
                    vec++;
                    bad++;
                    $display("FAIL spurious_out: got 0x%0h, expected no output", out_data);
                end else begin
                    ge = exp_q.pop_front();
                    check("out_data", out_data, ge.d);
                    check("out_ch", out_ch, ge.c);
                    check("out_last", out_last, ge.l);
                    if (ge.l) free_evt = 1;
                end
            end
            check("drop_cnt", drop_cnt, exp_drop);
            check("overflow", overflow, exp_ovf);
            stall = out_vaild && !out_ready;
            pd = out_data;
            pc = out_ch;
            pl = out_last;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [W-1:0] d);
        ad_data = d;
        ad_vaild = 1'b1;
        tick();
        ad_vaild = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || held != 0) && n < 300) begin
            tick();
            n++;
        end
        check("drain_qsize", exp_q.size(), 0);
        check("drain_held", held, 0);
        repeat (2) tick();
    endtask

    task automatic rst_vals(input string tag);
        check({tag, "_vaild"}, out_vaild, 0);
        check({tag, "_ovf"}, overflow, 0);
        check({tag, "_drop"}, drop_cnt, 0);
        check({tag, "_data"}, out_data, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 reset = 1'b0;
        #2 rst_vals("rst");
        repeat (2) tick();
        reset = 1'b1;
        mode = 1;
        repeat (2) tick();

        for (int i = 0; i < 8; i++) wr(W'(i));
        @(negedge clk) check("lat_c0", out_vaild, 0);
        @(negedge clk) check("lat_c1", out_vaild, 0);
        @(negedge clk) check("lat_c2", out_vaild, 1);
        drain();

        mode = 2;
        for (int i = 0; i < 8; i++) wr(W'(i));
        drain();
        mode = 1;

        mode = 0;
        repeat (2) tick();
        for (int i = 0; i < 24; i++) wr(W'(i));
        repeat (4) tick();
        check("t4_drop", drop_cnt, 8);
        check("t4_ovf", overflow, 1);
        mode = 1;
        drain();
        for (int i = 0; i < 8; i++) wr(W'(100 + i));
        drain();

        mode = 0;
        tick();
        for (int i = 0; i < 8; i++) wr(W'(50 + i));
        repeat (4) tick();
        check("pre_rst_vaild", out_vaild, 1);
        @(negedge clk);
        #2 reset = 1'b0;
        #1 rst_vals("midrst");
        @(negedge clk) rst_vals("midrst_next");
        tick();
        reset = 1'b1;

        mode = 1;
        repeat (2) tick();
        coincide = 0;
        for (int i = 0; i < 8; i++) wr(W'(300 + i));
        repeat (2) tick();
        for (int i = 0; i < 8; i++) wr(W'(400 + i));
        for (int i = 0; i < 8; i++) wr(W'(500 + i));
        drain();
        check("t5_coincide", coincide, 1);
        check("t5_drop", drop_cnt, 0);

        mode = 0;
        repeat (2) tick();
        for (int i = 0; i < 16; i++) wr(W'(600 + i));
        wr(16'h0dd1);
        check("t6_ovf_set", overflow, 1);
        clr_ovf = 1'b1;
        wr(16'h0dd2);
        clr_ovf = 1'b0;
        check("t6_ovf_clr", overflow, 0);
        check("t6_drop_clr", drop_cnt, 0);
        mode = 1;
        drain();

        mode = 2;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) != 0) wr(W'($urandom));
            else tick();
        end
        mode = 1;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end
endmodule
